// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, opcodes, default widths and
// the ID/EX payload width helper.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam int ALU_OP_W = 3;
  localparam int IMM16_W  = 16;
  localparam int FUNCT_W  = 6;
  localparam int OPCODE_W = 6;

  localparam logic [ALU_OP_W-1:0] ALU_R_TYPE = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADDI   = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLTIU  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ    = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_LUI    = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_ORI    = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_BNE    = 3'd6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;

  // regwrite, alusrc, branch, branch_eq + alu_op + funct + pc/rs/rt/imm + wreg
  function automatic int payload_w(input int dw, input int aw);
    return 4 + ALU_OP_W + FUNCT_W + 4 * dw + aw;
  endfunction

endpackage

// File: rtl/idex_payload_reg.sv
// Flat payload register with load enable; one instance holds the entry
// visible to EX, the other is the skid entry.
module idex_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     data_q <= '0;
    else if (ld_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// Elastic ID/EX boundary: main register + 2nd skid entry, flush, and a
// saturating stall counter. in_ready_o depends only on the skid flop.
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                regwrite_i,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic                alusrc_i,
  input  logic                regdst_i,
  input  logic                branch_i,
  input  logic                branch_eq_i,
  input  logic [DATA_W-1:0]   pc_plus4_i,
  input  logic [DATA_W-1:0]   rs_data_i,
  input  logic [DATA_W-1:0]   rt_data_i,
  input  logic [IMM16_W-1:0]  imm16_i,
  input  logic [REG_AW-1:0]   rt_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_regwrite_o,
  output logic [ALU_OP_W-1:0] out_alu_op_o,
  output logic                out_alusrc_o,
  output logic                out_branch_o,
  output logic                out_branch_eq_o,
  output logic [DATA_W-1:0]   out_pc_plus4_o,
  output logic [DATA_W-1:0]   out_rs_data_o,
  output logic [DATA_W-1:0]   out_rt_data_o,
  output logic [FUNCT_W-1:0]  out_funct_o,
  output logic [DATA_W-1:0]   out_imm_o,
  output logic [REG_AW-1:0]   out_wreg_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam int PW = payload_w(DATA_W, REG_AW);

  logic [DATA_W-1:0] imm_ext;
  logic [REG_AW-1:0] wreg;
  logic [PW-1:0]     in_pl, main_pl_d, main_pl_q, skid_pl_q;
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic              main_ld, skid_ld, acc, main_free;
  logic [CNT_W-1:0]  stall_q;
  logic              raw_regwrite, raw_branch;

  always_comb begin
    if (alu_op_i == ALU_ORI) imm_ext = {{(DATA_W-IMM16_W){1'b0}}, imm16_i};
    else                     imm_ext = {{(DATA_W-IMM16_W){imm16_i[IMM16_W-1]}}, imm16_i};
  end

  assign wreg  = regdst_i ? rd_i : rt_i;
  assign in_pl = {regwrite_i, alu_op_i, alusrc_i, branch_i, branch_eq_i,
                  pc_plus4_i, rs_data_i, rt_data_i, funct_i, imm_ext, wreg};

  assign in_ready_o = ~skid_vld_q;
  // An input arriving with a flush belongs to the killed path.
  assign acc        = in_valid_i & in_ready_o & ~flush_i;
  assign main_free  = ~main_vld_q | out_ready_i;

  // in_ready_o is low whenever skid is valid, so skid and input never compete.
  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_ld    = 1'b0;
    skid_ld    = 1'b0;
    main_pl_d  = skid_vld_q ? skid_pl_q : in_pl;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_free) begin
      main_vld_d = skid_vld_q | acc;
      main_ld    = skid_vld_q | acc;
      skid_vld_d = 1'b0;
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_ld    = 1'b1;
    end
  end

  idex_payload_reg #(.W(PW)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .ld_i(main_ld), .d_i(main_pl_d), .q_o(main_pl_q)
  );

  idex_payload_reg #(.W(PW)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .ld_i(skid_ld), .d_i(in_pl), .q_o(skid_pl_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      if (main_vld_q && !out_ready_i && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign {raw_regwrite, out_alu_op_o, out_alusrc_o, raw_branch, out_branch_eq_o,
          out_pc_plus4_o, out_rs_data_o, out_rt_data_o, out_funct_o,
          out_imm_o, out_wreg_o} = main_pl_q;

  // Side-effect controls are masked so a stale payload cannot act in EX.
  assign out_regwrite_o = raw_regwrite & main_vld_q;
  assign out_branch_o   = raw_branch & main_vld_q;
  assign out_valid_o    = main_vld_q;
  assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: expected payloads are queued on accept
// and compared in order when EX consumes them.
module tb_id_ex_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic        regwrite_i = 1'b0, alusrc_i = 1'b0, regdst_i = 1'b0;
  logic        branch_i = 1'b0, branch_eq_i = 1'b0;
  logic [2:0]  alu_op_i = '0;
  logic [31:0] pc_plus4_i = '0, rs_data_i = '0, rt_data_i = '0;
  logic [15:0] imm16_i = '0;
  logic [4:0]  rt_i = '0, rd_i = '0;
  logic [5:0]  funct_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o, out_ready_i = 1'b1;
  logic        out_regwrite_o, out_alusrc_o, out_branch_o, out_branch_eq_o;
  logic [2:0]  out_alu_op_o;
  logic [31:0] out_pc_plus4_o, out_rs_data_o, out_rt_data_o, out_imm_o;
  logic [5:0]  out_funct_o;
  logic [4:0]  out_wreg_o;
  logic [15:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  id_ex_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .regwrite_i(regwrite_i), .alu_op_i(alu_op_i), .alusrc_i(alusrc_i), .regdst_i(regdst_i),
    .branch_i(branch_i), .branch_eq_i(branch_eq_i), .pc_plus4_i(pc_plus4_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm16_i(imm16_i), .rt_i(rt_i),
    .rd_i(rd_i), .funct_i(funct_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_regwrite_o(out_regwrite_o), .out_alu_op_o(out_alu_op_o),
    .out_alusrc_o(out_alusrc_o), .out_branch_o(out_branch_o), .out_branch_eq_o(out_branch_eq_o),
    .out_pc_plus4_o(out_pc_plus4_o), .out_rs_data_o(out_rs_data_o),
    .out_rt_data_o(out_rt_data_o), .out_funct_o(out_funct_o), .out_imm_o(out_imm_o),
    .out_wreg_o(out_wreg_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic regwrite; logic [2:0] alu_op; logic alusrc, regdst, branch, branch_eq;
    logic [31:0] pc, rs, rtd; logic [15:0] imm16; logic [4:0] rt, rd; logic [5:0] funct;
  } instr_t;

  logic [255:0] sb[$];
  instr_t       cur;
  int           n_chk = 0, n_fail = 0, n_out = 0;
  bit           acc_last;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_of(input instr_t x);
    logic [31:0] imm;
    imm = (x.alu_op == 3'd5) ? {16'h0, x.imm16} : {{16{x.imm16[15]}}, x.imm16};
    return {110'b0, x.regwrite, x.alu_op, x.alusrc, x.branch, x.branch_eq,
            x.pc, x.rs, x.rtd, x.funct, imm, (x.regdst ? x.rd : x.rt)};
  endfunction

  function automatic logic [255:0] act_vec();
    return {110'b0, out_regwrite_o, out_alu_op_o, out_alusrc_o, out_branch_o, out_branch_eq_o,
            out_pc_plus4_o, out_rs_data_o, out_rt_data_o, out_funct_o, out_imm_o, out_wreg_o};
  endfunction

  function automatic instr_t rnd();
    instr_t x;
    x.regwrite = 1'($urandom); x.alu_op = 3'($urandom_range(0, 6)); x.alusrc = 1'($urandom);
    x.regdst = 1'($urandom); x.branch = 1'($urandom); x.branch_eq = 1'($urandom);
    x.pc = $urandom; x.rs = $urandom; x.rtd = $urandom; x.imm16 = 16'($urandom);
    x.rt = 5'($urandom); x.rd = 5'($urandom); x.funct = 6'($urandom);
    return x;
  endfunction

  task automatic present(input instr_t x, input logic v);
    cur = x; in_valid_i = v;
    regwrite_i = x.regwrite; alu_op_i = x.alu_op; alusrc_i = x.alusrc; regdst_i = x.regdst;
    branch_i = x.branch; branch_eq_i = x.branch_eq; pc_plus4_i = x.pc; rs_data_i = x.rs;
    rt_data_i = x.rtd; imm16_i = x.imm16; rt_i = x.rt; rd_i = x.rd; funct_i = x.funct;
  endtask

  // One clock: monitor at negedge, then advance to just after the edge.
  task automatic step();
    @(negedge clk_i);
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", 256'd1, 256'd0);
      else chk("sb_payload", act_vec(), sb.pop_front());
      n_out++;
    end
    acc_last = !rst_i && !flush_i && in_valid_i && in_ready_o;
    if (acc_last) sb.push_back(exp_of(cur));
    if (flush_i || rst_i) sb.delete();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
  endtask

  initial begin
    instr_t x;
    instr_t st[4];
    int n0, bad, sent;

    do_reset();
    chk("rst_valid", 256'(out_valid_o), 256'd0);
    chk("rst_inrdy", 256'(in_ready_o), 256'd1);
    chk("rst_stall", 256'(stall_cnt_o), 256'd0);
    chk("rst_payload", act_vec(), 256'd0);

    // ADDI with negative immediate
    x = rnd(); x.alu_op = 3'd1; x.imm16 = 16'hFFFC; x.rt = 5'd5; x.regdst = 1'b0;
    present(x, 1'b1); step();
    present(x, 1'b0);
    chk("addi_valid", 256'(out_valid_o), 256'd1);
    chk("addi_imm", 256'(out_imm_o), 256'hFFFFFFFC);
    chk("addi_wreg", 256'(out_wreg_o), 256'd5);
    chk("addi_op", 256'(out_alu_op_o), 256'd1);
    step();

    // ORI zero-extends; R-type selects rd
    x = rnd(); x.alu_op = 3'd5; x.imm16 = 16'h8001;
    present(x, 1'b1); step();
    present(x, 1'b0);
    chk("ori_imm", 256'(out_imm_o), 256'h00008001);
    x = rnd(); x.alu_op = 3'd0; x.rd = 5'd9; x.rt = 5'd3; x.regdst = 1'b1;
    present(x, 1'b1); step();
    present(x, 1'b0);
    chk("rtype_wreg", 256'(out_wreg_o), 256'd9);
    step();

    // Stream 4 with EX stalled for three cycles
    for (int i = 0; i < 4; i++) st[i] = rnd();
    n0 = n_out; sent = 0;
    for (int k = 0; k < 12; k++) begin
      out_ready_i = !(k >= 1 && k <= 3);
      if (k == 2 || k == 3) begin
        chk("skid_inrdy", 256'(in_ready_o), 256'd0);
        chk("skid_hold1", 256'(out_pc_plus4_o), 256'(st[0].pc));
      end
      if (sent < 4) present(st[sent], 1'b1); else present(st[0], 1'b0);
      step();
      if (acc_last) sent++;
    end
    chk("stream_cnt", 256'(n_out - n0), 256'd4);
    chk("stream_stall", 256'(stall_cnt_o), 256'd3);
    chk("stream_sb_empty", 256'(sb.size()), 256'd0);

    // Flush with main and skid full; stale payload must not leak controls
    out_ready_i = 1'b0;
    x = rnd(); x.regwrite = 1'b1; x.branch = 1'b1;
    present(x, 1'b1); step();
    present(rnd(), 1'b1); step();
    present(rnd(), 1'b1); flush_i = 1'b1; step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_valid", 256'(out_valid_o), 256'd0);
    chk("flush_inrdy", 256'(in_ready_o), 256'd1);
    chk("flush_mask", 256'({out_regwrite_o, out_branch_o}), 256'd0);

    // Flush while EX consumes and in_ready_o=1: output delivered, input dropped
    out_ready_i = 1'b1; n0 = n_out;
    present(rnd(), 1'b1); step();
    present(rnd(), 1'b1); flush_i = 1'b1; step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush2_valid", 256'(out_valid_o), 256'd0);
    present(rnd(), 1'b1); step();
    in_valid_i = 1'b0; step(); step();
    chk("flush2_cnt", 256'(n_out - n0), 256'd2);
    chk("flush2_sb_empty", 256'(sb.size()), 256'd0);

    // Back-to-back 100
    do_reset();
    n0 = n_out; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!in_ready_o) bad++;
      present(rnd(), 1'b1); step();
    end
    in_valid_i = 1'b0; step(); step();
    chk("bb_cnt", 256'(n_out - n0), 256'd100);
    chk("bb_inrdy_low", 256'(bad), 256'd0);
    chk("bb_stall", 256'(stall_cnt_o), 256'd0);

    // Saturation then reset mid-stall
    do_reset();
    present(rnd(), 1'b1); step();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    for (int i = 0; i < (1 << 16) + 5; i++) step();
    chk("sat_stall", 256'(stall_cnt_o), 256'hFFFF);
    chk("sat_valid", 256'(out_valid_o), 256'd1);
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("midrst_valid", 256'(out_valid_o), 256'd0);
    chk("midrst_stall", 256'(stall_cnt_o), 256'd0);
    chk("midrst_payload", act_vec(), 256'd0);
    chk("midrst_inrdy", 256'(in_ready_o), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
